// File: rtl/uart_rx_fifo_pkg.sv
// Shared types for the UART receive buffer: the stored entry layout and the
// receive trigger-level encoding.
package uart_pkg;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  localparam int RX_ENTRY_W = $bits(rx_entry_t);

  typedef enum logic [1:0] {
    TRIG_1  = 2'd0,
    TRIG_4  = 2'd1,
    TRIG_8  = 2'd2,
    TRIG_14 = 2'd3
  } rx_trig_e;

  function automatic logic [4:0] trig_level(rx_trig_e t);
    logic [4:0] lvl;
    case (t)
      TRIG_1:  lvl = 5'd1;
      TRIG_4:  lvl = 5'd4;
      TRIG_8:  lvl = 5'd8;
      TRIG_14: lvl = 5'd14;
      default: lvl = 5'd1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Character path between the receiver, the receive buffer and the RBR read logic.
//
// Handshakes: rx_valid is a one-cycle push with no back-pressure. The buffer
// holds rbr_valid high while its head entry is present. The head is consumed
// on a cycle where rbr_valid && rbr_ready; rbr_ready alone has no effect.
interface uart_rx_fifo_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_pe;
  logic       rx_fe;
  logic       rx_bi;

  logic       rbr_valid;
  logic       rbr_ready;
  logic [7:0] rbr_data;
  logic       rbr_pe;
  logic       rbr_fe;
  logic       rbr_bi;

  modport master (
    output rx_valid, rx_data, rx_pe, rx_fe, rx_bi, rbr_ready,
    input  rbr_valid, rbr_data, rbr_pe, rbr_fe, rbr_bi
  );

  modport slave (
    input  rx_valid, rx_data, rx_pe, rx_fe, rx_bi, rbr_ready,
    output rbr_valid, rbr_data, rbr_pe, rbr_fe, rbr_bi
  );
endinterface

// File: rtl/uart_rx_fifo_fifo.sv
// First-word-fall-through storage. The caller gates push/pop; single mode
// pins both pointers to slot 0 so the buffer acts as one holding register.
module uart_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     srst,
  input  logic                     single,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   push_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  always_ff @(posedge clk) begin
    if (push && !srst) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= single ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= single ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Stale storage is masked so an empty buffer presents all-zero data.
  assign rdata    = (cnt != '0) ? mem[rd_ptr] : '0;
  assign push_cnt = cnt;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: stores characters with their error flags and derives
// occupancy, overrun, trigger, character-timeout and error-in-buffer status.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TO_CHARS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_rx_fifo_if.slave          rx_if,
  input  logic                   char_tick,
  input  logic                   cfg_fifo_enable,
  input  logic                   cfg_rx_reset,
  input  logic [1:0]             cfg_rx_trig,
  output logic [$clog2(DEPTH):0] rx_cnt,
  output logic                   rx_overrun,
  output logic                   rx_err_in_fifo,
  output logic                   rx_trigger,
  output logic                   rx_timeout
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(TO_CHARS + 1);

  rx_entry_t             wr_entry;
  rx_entry_t             head;
  logic [RX_ENTRY_W-1:0] head_bits;
  logic                  en_q;
  logic                  flush;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  push_err;
  logic                  pop_err;
  logic [CW-1:0]         cap;
  logic [CW-1:0]         err_cnt;
  logic [IW-1:0]         idle_cnt;

  assign wr_entry = '{bi: rx_if.rx_bi, fe: rx_if.rx_fe, pe: rx_if.rx_pe, data: rx_if.rx_data};
  assign head     = rx_entry_t'(head_bits);

  // A mode change flushes, so entries never straddle the two pointer schemes.
  assign flush    = cfg_rx_reset || (cfg_fifo_enable != en_q);
  assign cap      = cfg_fifo_enable ? CW'(DEPTH) : CW'(1);
  assign full     = (rx_cnt == cap);
  assign push     = rx_if.rx_valid && !full && !flush;
  assign pop      = rx_if.rbr_valid && rx_if.rbr_ready && !flush;
  assign push_err = push && (rx_if.rx_pe || rx_if.rx_fe || rx_if.rx_bi);
  assign pop_err  = pop && (head.pe || head.fe || head.bi);

  uart_fifo #(
    .WIDTH(RX_ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .srst    (flush),
    .single  (!cfg_fifo_enable),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_entry),
    .rdata   (head_bits),
    .push_cnt(rx_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      en_q       <= cfg_fifo_enable;
      rx_overrun <= rx_if.rx_valid && full && !flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (flush) begin
      err_cnt <= '0;
    end else if (push_err && !pop_err) begin
      err_cnt <= err_cnt + 1'b1;
    end else if (pop_err && !push_err) begin
      err_cnt <= err_cnt - 1'b1;
    end
  end

  // Idle time only accumulates while characters sit unread in the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (flush || push || pop || rx_cnt == '0) begin
      idle_cnt <= '0;
    end else if (char_tick && idle_cnt != IW'(TO_CHARS)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign rx_if.rbr_valid = (rx_cnt != '0);
  assign rx_if.rbr_data  = head.data;
  assign rx_if.rbr_pe    = head.pe;
  assign rx_if.rbr_fe    = head.fe;
  assign rx_if.rbr_bi    = head.bi;

  assign rx_err_in_fifo = (err_cnt != '0);
  assign rx_trigger     = cfg_fifo_enable ? (rx_cnt >= CW'(trig_level(rx_trig_e'(cfg_rx_trig))))
                                          : rx_if.rbr_valid;
  assign rx_timeout     = cfg_fifo_enable && (rx_cnt != '0) && (idle_cnt == IW'(TO_CHARS));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios followed by random traffic, all
// checked every cycle against a queue-based model of the buffer behaviour.
module tb_uart_rx_fifo;
  localparam int DEPTH    = 16;
  localparam int TO_CHARS = 4;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          char_tick = 1'b0;
  logic          cfg_fifo_enable = 1'b1;
  logic          cfg_rx_reset = 1'b0;
  logic [1:0]    cfg_rx_trig = 2'd2;
  logic [CW-1:0] rx_cnt;
  logic          rx_overrun;
  logic          rx_err_in_fifo;
  logic          rx_trigger;
  logic          rx_timeout;

  uart_rx_fifo_if rx_if ();

  uart_rx_fifo #(
    .DEPTH   (DEPTH),
    .TO_CHARS(TO_CHARS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_if          (rx_if),
    .char_tick      (char_tick),
    .cfg_fifo_enable(cfg_fifo_enable),
    .cfg_rx_reset   (cfg_rx_reset),
    .cfg_rx_trig    (cfg_rx_trig),
    .rx_cnt         (rx_cnt),
    .rx_overrun     (rx_overrun),
    .rx_err_in_fifo (rx_err_in_fifo),
    .rx_trigger     (rx_trigger),
    .rx_timeout     (rx_timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state: stored entries as {bi,fe,pe,data}
  logic [10:0] exp_q[$];
  bit          m_ovr;
  int          m_idle;
  bit          m_prev_en;
  int          lvl_tab[4] = '{1, 4, 8, 14};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [10:0] hd;
    int          n;
    bit          any_err;
    bit          trig_exp;
    n       = exp_q.size();
    hd      = (n != 0) ? exp_q[0] : 11'h000;
    any_err = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][10:8] != 3'b000) any_err = 1'b1;
    trig_exp = cfg_fifo_enable ? (n >= lvl_tab[cfg_rx_trig]) : (n != 0);
    check("rbr_valid", 32'(rx_if.rbr_valid), 32'(n != 0));
    check("rbr_data", 32'(rx_if.rbr_data), 32'(hd[7:0]));
    check("rbr_pe", 32'(rx_if.rbr_pe), 32'(hd[8]));
    check("rbr_fe", 32'(rx_if.rbr_fe), 32'(hd[9]));
    check("rbr_bi", 32'(rx_if.rbr_bi), 32'(hd[10]));
    check("rx_cnt", 32'(rx_cnt), n);
    check("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
    check("rx_err_in_fifo", 32'(rx_err_in_fifo), 32'(any_err));
    check("rx_trigger", 32'(rx_trigger), 32'(trig_exp));
    check("rx_timeout", 32'(rx_timeout),
          32'(cfg_fifo_enable && n != 0 && m_idle == TO_CHARS));
  endtask

  // driver: one clock cycle of stimulus, model update, then full output check
  task automatic step(input bit rv, input logic [7:0] d, input logic [2:0] f,
                      input bit rdy, input bit tick, input bit rrst);
    int          cap;
    bit          full;
    bit          was_empty;
    bit          do_pop;
    bit          do_push;
    bit          flush;
    logic [10:0] dummy;
    @(negedge clk);
    rx_if.rx_valid  = rv;
    rx_if.rx_data   = d;
    {rx_if.rx_bi, rx_if.rx_fe, rx_if.rx_pe} = f;
    rx_if.rbr_ready = rdy;
    char_tick       = tick;
    cfg_rx_reset    = rrst;
    @(posedge clk);
    flush     = rrst || (cfg_fifo_enable != m_prev_en);
    cap       = cfg_fifo_enable ? DEPTH : 1;
    full      = (exp_q.size() == cap);
    was_empty = (exp_q.size() == 0);
    do_pop    = !was_empty && rdy;
    do_push   = rv && !full;
    if (flush) begin
      exp_q.delete();
      m_ovr  = 1'b0;
      m_idle = 0;
    end else begin
      m_ovr = rv && full;
      if (do_pop) dummy = exp_q.pop_front();
      if (do_push) exp_q.push_back({f, d});
      if (do_push || do_pop || was_empty) m_idle = 0;
      else if (tick && m_idle < TO_CHARS) m_idle++;
    end
    m_prev_en = cfg_fifo_enable;
    #1;
    check_outputs();
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] f);
    step(1'b1, d, f, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit tick);
    step(1'b0, 8'h00, 3'b000, 1'b0, tick, 1'b0);
  endtask

  initial begin
    rx_if.rx_valid  = 1'b0;
    rx_if.rx_data   = 8'h00;
    rx_if.rx_pe     = 1'b0;
    rx_if.rx_fe     = 1'b0;
    rx_if.rx_bi     = 1'b0;
    rx_if.rbr_ready = 1'b0;
    m_ovr  = 1'b0;
    m_idle = 0;

    // reset state
    #12;
    check_outputs();
    @(negedge clk);
    rst_n     = 1'b1;
    m_prev_en = cfg_fifo_enable;
    idle(1'b0);
    idle(1'b0);

    // FIFO mode fill to capacity, overrun, drain in order
    for (int i = 1; i <= 16; i++) begin
      push(8'(i), 3'b000);
      if (i == 7) check("trig_before_8", 32'(rx_trigger), 32'd0);
      if (i == 8) check("trig_at_8", 32'(rx_trigger), 32'd1);
    end
    check("fill_cnt", 32'(rx_cnt), 32'd16);
    push(8'h11, 3'b000);
    check("ovr_pulse", 32'(rx_overrun), 32'd1);
    idle(1'b0);
    check("ovr_one_cycle", 32'(rx_overrun), 32'd0);
    // overrun even while a pop happens in the same cycle
    step(1'b1, 8'h12, 3'b000, 1'b1, 1'b0, 1'b0);
    check("ovr_with_pop", 32'(rx_overrun), 32'd1);
    for (int i = 0; i < 15; i++) pop_one();
    check("drain_empty", 32'(rx_if.rbr_valid), 32'd0);
    pop_one();

    // error flag tracking
    push(8'h41, 3'b010);
    push(8'h42, 3'b000);
    check("err_set", 32'(rx_err_in_fifo), 32'd1);
    pop_one();
    check("err_clear", 32'(rx_err_in_fifo), 32'd0);
    pop_one();
    push(8'h43, 3'b100);
    step(1'b1, 8'h44, 3'b001, 1'b1, 1'b0, 1'b0);
    check("err_push_pop_same", 32'(rx_err_in_fifo), 32'd1);
    pop_one();
    check("err_after_last", 32'(rx_err_in_fifo), 32'd0);

    // character timeout in FIFO mode
    push(8'h55, 3'b000);
    for (int i = 0; i < TO_CHARS; i++) idle(1'b1);
    check("timeout_set", 32'(rx_timeout), 32'd1);
    idle(1'b1);
    pop_one();
    check("timeout_clear", 32'(rx_timeout), 32'd0);

    // single-register mode
    cfg_fifo_enable = 1'b0;
    idle(1'b0);
    push(8'hA5, 3'b000);
    push(8'h5A, 3'b000);
    check("single_ovr", 32'(rx_overrun), 32'd1);
    check("single_hold", 32'(rx_if.rbr_data), 32'h0A5);
    for (int i = 0; i < TO_CHARS + 1; i++) idle(1'b1);
    check("single_no_timeout", 32'(rx_timeout), 32'd0);
    pop_one();
    push(8'h3C, 3'b001);
    step(1'b1, 8'hC3, 3'b000, 1'b1, 1'b0, 1'b0);
    pop_one();

    // flush via cfg_rx_reset with a simultaneous push, then via mode toggle
    cfg_fifo_enable = 1'b1;
    idle(1'b0);
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 3'b010);
    step(1'b1, 8'h99, 3'b000, 1'b0, 1'b0, 1'b1);
    check("flush_cnt", 32'(rx_cnt), 32'd0);
    check("flush_no_ovr", 32'(rx_overrun), 32'd0);
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i), 3'b000);
    cfg_fifo_enable = 1'b0;
    idle(1'b0);
    check("toggle_flush", 32'(rx_cnt), 32'd0);
    cfg_fifo_enable = 1'b1;
    idle(1'b0);

    // asynchronous reset in the middle of traffic
    push(8'h77, 3'b000);
    push(8'h78, 3'b001);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_ovr  = 1'b0;
    m_idle = 0;
    check("async_rst_cnt", 32'(rx_cnt), 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n     = 1'b1;
    m_prev_en = cfg_fifo_enable;
    idle(1'b0);
    push(8'h81, 3'b000);
    check("post_rst_head", 32'(rx_if.rbr_data), 32'h081);
    pop_one();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int rdy_pct;
      rdy_pct = (i < 300) ? 20 : 70;
      if ($urandom_range(0, 99) < 5) cfg_rx_trig = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) cfg_fifo_enable = !cfg_fifo_enable;
      step($urandom_range(0, 99) < 45, 8'($urandom), ($urandom_range(0, 99) < 15) ? 3'($urandom) : 3'b000,
           $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer of the UART, between the receiver deserializer and the RBR/LSR register logic. Stores each received character together with its parity, framing and break error flags. Reports occupancy, overrun, the receive trigger level, the character timeout and the "error in FIFO" condition. In FIFO mode it holds up to DEPTH entries; with the FIFO disabled it behaves as the single RBR holding register.

## Interface
- `DEPTH`, default 16: entries in FIFO mode, a power of two ≥ 16.
- `TO_CHARS`, default 4: idle character times before the timeout indication asserts.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: one-cycle pulse, receiver has a complete character. No back-pressure.
- `rx_data` in 8: received character.
- `rx_pe`, `rx_fe`, `rx_bi` in 1 each: parity error, framing error and break flags for that character.
- `rbr_valid` out 1: head entry available.
- `rbr_ready` in 1: pop the head entry (RBR read).
- `rbr_data` out 8: head character.
- `rbr_pe`, `rbr_fe`, `rbr_bi` out 1 each: head entry error flags.
- `rx_cnt` out $clog2(DEPTH)+1: current occupancy.
- `rx_overrun` out 1: one-cycle pulse, a character was lost.
- `rx_err_in_fifo` out 1: at least one stored entry has PE, FE or BI set.
- `rx_trigger` out 1: occupancy ≥ trigger level.
- `rx_timeout` out 1: character timeout pending.
- `char_tick` in 1: one-cycle pulse per character time, from the baud generator.
- `cfg_fifo_enable` in 1: FIFO mode (1) or single-register mode (0).
- `cfg_rx_reset` in 1: synchronous flush.
- `cfg_rx_trig` in 2: trigger level select; 0,1,2,3 map to 1,4,8,14 entries.

## Operation
- **Capacity:** DEPTH when `cfg_fifo_enable`=1, otherwise 1.
- **Full:** full means `rx_cnt` equals the capacity, taken from the registered count.
- **Push:**
  - A push occurs on `rx_valid` when the FIFO is not full.
  - When full, the character is discarded, the contents are kept and `rx_overrun` pulses.
  - A push on a full FIFO while a pop happens in the same cycle is still an overrun.
- **Pop:** a pop occurs on `rbr_valid && rbr_ready`. `rbr_ready` while empty is ignored.
- **Error-entry counter:**
  - The counter increments on a push with any error flag set.
  - It decrements on a pop of a head entry with any error flag set.
  - Both in the same cycle leave it unchanged.
  - `rx_err_in_fifo` = (counter ≠ 0).
- **Trigger:** `rx_trigger` = `rx_cnt` ≥ the selected level in FIFO mode, and = `rbr_valid` in single-register mode.
- **Timeout:**
  - An idle counter clears on any push, any pop, or an empty FIFO.
  - Otherwise it increments on `char_tick`, saturating at TO_CHARS.
  - `rx_timeout` = `cfg_fifo_enable` && `rx_cnt` ≠ 0 && idle counter == TO_CHARS.
- **Flush:**
  - Either `cfg_rx_reset`=1 or a change of `cfg_fifo_enable` (internally detected edge) triggers a flush.
  - A flush clears pointers, the count, the error-entry counter and the idle counter.
  - It has priority over a push or pop in the same cycle; that push is dropped without signalling overrun.

## Timing
- **Reset values:** all outputs 0 (`rbr_valid`, `rbr_data`, flags, `rx_cnt`, `rx_overrun`, `rx_err_in_fifo`, `rx_trigger`, `rx_timeout`).
- **Head visibility:** first-word-fall-through. A character pushed in cycle N appears on `rbr_*` with `rbr_valid`=1 in cycle N+1.
- **Pop in cycle N:** the next entry, or `rbr_valid`=0, is shown in cycle N+1.
- **Registered status:**
  - `rx_cnt`, `rx_err_in_fifo` and `rx_trigger` update in the cycle after the push/pop.
  - `rx_timeout` asserts the cycle after the TO_CHARS-th qualifying `char_tick`.
  - It drops the cycle after a push, pop or flush.
- **Overrun:** `rx_overrun` is asserted in cycle N+1 for a rejected push in cycle N, for exactly 1 cycle.
- **Flush:** takes effect at the next edge; outputs read as reset values the following cycle.
- **Pointers:** wrap modulo DEPTH. In single-register mode only slot 0 is used.
- **Reset mid-operation:** `rst_n` low clears everything immediately (asynchronous); entries are lost.

## Structure
- **uart_pkg:**
  - `rx_entry_t` packed struct {bi, fe, pe, data[7:0]} (11 bits).
  - `rx_trig_e` enum (TRIG_1, TRIG_4, TRIG_8, TRIG_14).
  - Function mapping `rx_trig_e` to a level.
- **Storage:** one `uart_fifo` instance with WIDTH = 11 carrying `rx_entry_t`. Its srst is driven by the flush condition and its push_cnt output by `rx_cnt`.
- **Logic in this module:** overrun detection, error-entry counter, idle/timeout counter, trigger compare and enable-edge detector.

## Test plan
- **FIFO mode fill and overrun:** with FIFO mode, trig=2, push 0x01..0x10, 16 chars. Expect `rx_trigger`=1 after the 8th push and `rx_cnt`=16. Then push 0x11 → `rx_overrun` pulses once and the contents are unchanged. Pops return 0x01..0x10 in order.
- **Error-flag tracking:** push 0x41 with FE=1, then 0x42 clean. Expect `rx_err_in_fifo`=1. Pop 0x41 → `rx_err_in_fifo`=0 the next cycle. Push with PE on the same cycle as popping a BI head → flag stays 1.
- **Timeout:** push one char, then send 4 `char_tick` with no pop → `rx_timeout`=1. Pop → `rx_timeout`=0 the next cycle. With FIFO disabled, the same stimulus gives `rx_timeout`=0.
- **Single-register mode:** FIFO disabled. Push 0xA5, then push 0x5A without popping → overrun, and `rbr_data` stays 0xA5.
- **Flush:** with 5 entries stored, assert `cfg_rx_reset` together with `rx_valid` → next cycle `rx_cnt`=0, `rbr_valid`=0, no overrun. Toggling `cfg_fifo_enable` with 3 entries also empties the FIFO.
- **Async reset:** assert `rst_n`=0 mid-stream → all outputs 0 immediately. After release, the first push appears at `rbr_data` one cycle later.
